// File: rtl/dcm_prog_ctrl.sv
// Serial M/D reprogramming sequencer for a DCM_CLKGEN (PROGCLK/PROGEN/PROGDATA),
// with PROGDONE/LOCKED confirmation and reset-and-retry recovery.
module dcm_prog_ctrl #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [8:0] cfg_m,
    input  logic [8:0] cfg_d,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    input  logic       dcm_locked,
    output logic       dcm_rst,
    output logic       busy,
    output logic       done_pulse,
    output logic       cfg_err,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE, LOAD_D, GAP_A, LOAD_M, GAP_B, GO, WAIT_DONE, WAIT_LOCK, RECOVER
    } state_t;

    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LOAD_LAST    = 16'd9;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d, retryNext;
    logic [7:0]  m1_q, m1_d, d1_q, d1_d;
    logic        err_q, err_d;
    logic        cfgReady_q, cfgReady_d;
    logic        progEn_q, progEn_d;
    logic        progData_q, progData_d;
    logic        dcmRst_q, dcmRst_d;
    logic        busy_q, busy_d;
    logic        donePulse_q, donePulse_d;
    logic        cfgErr_q, cfgErr_d;
    logic        cfgIllegal;
    logic [2:0]  bitIdx;

    // Outputs are derived from the next state so every pin is a flop that
    // changes on the same edge as the state it belongs to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        retry_d     = retry_q;
        retryNext   = retry_q + 8'd1;
        m1_d        = m1_q;
        d1_d        = d1_q;
        err_d       = err_q;
        donePulse_d = 1'b0;
        cfgErr_d    = 1'b0;
        cfgIllegal  = (cfg_m < 9'd2) || (cfg_m > 9'd256) ||
                      (cfg_d == 9'd0) || (cfg_d > 9'd256);

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (cfg_valid && cfgReady_q) begin
                    if (cfgIllegal) begin
                        cfgErr_d = 1'b1;
                    end else begin
                        m1_d    = cfg_m[7:0] - 8'd1;
                        d1_d    = cfg_d[7:0] - 8'd1;
                        err_d   = 1'b0;
                        retry_d = 8'd0;
                        state_d = LOAD_D;
                    end
                end
            end
            LOAD_D: if (cnt_q == LOAD_LAST) begin state_d = GAP_A; cnt_d = 16'd0; end
            GAP_A:  if (cnt_q == GAP_LAST)  begin state_d = LOAD_M; cnt_d = 16'd0; end
            LOAD_M: if (cnt_q == LOAD_LAST) begin state_d = GAP_B; cnt_d = 16'd0; end
            GAP_B:  if (cnt_q == GAP_LAST)  begin state_d = GO; cnt_d = 16'd0; end
            GO: begin
                state_d = WAIT_DONE;
                cnt_d   = 16'd0;
            end
            // Status is checked before the timeout so a same-cycle arrival wins.
            WAIT_DONE: begin
                if (prog_done) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = 16'd0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = RECOVER;
                    cnt_d   = 16'd0;
                end
            end
            WAIT_LOCK: begin
                if (dcm_locked) begin
                    state_d     = IDLE;
                    cnt_d       = 16'd0;
                    donePulse_d = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = RECOVER;
                    cnt_d   = 16'd0;
                end
            end
            RECOVER: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = 16'd0;
                    retry_d = retryNext;
                    if (32'(retryNext) <= RETRY_MAX) begin
                        state_d = LOAD_D;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        cfgReady_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        progEn_d   = (state_d == LOAD_D) || (state_d == LOAD_M) || (state_d == GO);
        dcmRst_d   = (state_d == RECOVER);
        bitIdx     = cnt_d[2:0] - 3'd2;
        progData_d = 1'b0;
        // Each load frame is a two-bit command header followed by the value LSB first.
        if (state_d == LOAD_D) begin
            if (cnt_d == 16'd0)      progData_d = 1'b1;
            else if (cnt_d == 16'd1) progData_d = 1'b0;
            else                     progData_d = d1_d[bitIdx];
        end else if (state_d == LOAD_M) begin
            if (cnt_d < 16'd2)       progData_d = 1'b1;
            else                     progData_d = m1_d[bitIdx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            retry_q     <= 8'd0;
            m1_q        <= 8'd0;
            d1_q        <= 8'd0;
            err_q       <= 1'b0;
            cfgReady_q  <= 1'b0;
            progEn_q    <= 1'b0;
            progData_q  <= 1'b0;
            dcmRst_q    <= 1'b0;
            busy_q      <= 1'b0;
            donePulse_q <= 1'b0;
            cfgErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            m1_q        <= m1_d;
            d1_q        <= d1_d;
            err_q       <= err_d;
            cfgReady_q  <= cfgReady_d;
            progEn_q    <= progEn_d;
            progData_q  <= progData_d;
            dcmRst_q    <= dcmRst_d;
            busy_q      <= busy_d;
            donePulse_q <= donePulse_d;
            cfgErr_q    <= cfgErr_d;
        end
    end

    assign cfg_ready  = cfgReady_q;
    assign prog_en    = progEn_q;
    assign prog_data  = progData_q;
    assign dcm_rst    = dcmRst_q;
    assign busy       = busy_q;
    assign done_pulse = donePulse_q;
    assign cfg_err    = cfgErr_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Self-checking bench for dcm_prog_ctrl: load frames are scoreboarded, the
// DCM status pins are driven by the test sequence.
module tb_dcm_prog_ctrl;

    localparam int GAP  = 2;
    localparam int TMO  = 100;
    localparam int RSTC = 16;
    localparam int RMAX = 3;

    logic       clk_in = 1'b0;
    logic       rstn_in = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [8:0] cfg_m = 9'd0;
    logic [8:0] cfg_d = 9'd0;
    logic       prog_done = 1'b0;
    logic       dcm_locked = 1'b0;
    logic       cfg_ready, prog_en, prog_data, dcm_rst, busy, done_pulse, cfg_err, err;

    dcm_prog_ctrl #(
        .GAP_CYCLES(GAP), .TIMEOUT(TMO), .RST_CYCLES(RSTC), .RETRY_MAX(RMAX)
    ) dut (
        .clk_in(clk_in), .rstn_in(rstn_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_m(cfg_m), .cfg_d(cfg_d),
        .prog_en(prog_en), .prog_data(prog_data),
        .prog_done(prog_done), .dcm_locked(dcm_locked), .dcm_rst(dcm_rst),
        .busy(busy), .done_pulse(done_pulse), .cfg_err(cfg_err), .err(err)
    );

    always #5 clk_in = ~clk_in;

    int checkCount = 0;
    int passCount  = 0;
    int expFrames[$];
    int edgeCount = 0;
    int runLen = 0, runStartEdge = 0, goEdge = 0, goCount = 0, enHighCount = 0;
    int rstLen = 0, rstPulses = 0, doneCount = 0, cfgErrCount = 0;
    logic [9:0] frameBits = 10'd0;
    logic abortRun = 1'b0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    always @(posedge clk_in) edgeCount++;

    // Collect PROGEN bursts into frames; bursts cut short by a reset are dropped.
    always @(negedge clk_in) begin
        if (prog_en) begin
            if (runLen == 0) runStartEdge = edgeCount;
            if (runLen < 10) frameBits[runLen] = prog_data;
            runLen++;
            enHighCount++;
        end else if (runLen > 0) begin
            if (abortRun) begin
            end else if (runLen == 1) begin
                goCount++;
                goEdge = runStartEdge;
            end else if (runLen == 10) begin
                if (expFrames.size() == 0) checkOutput("unexpectedFrame", int'(frameBits), -1);
                else checkOutput("frame", int'(frameBits), expFrames.pop_front());
            end else begin
                checkOutput("runLength", runLen, 10);
            end
            runLen = 0;
        end
        if (dcm_rst) rstLen++;
        else if (rstLen > 0) begin
            checkOutput("rstWidth", rstLen, RSTC);
            rstPulses++;
            rstLen = 0;
        end
        if (done_pulse) doneCount++;
        if (cfg_err) cfgErrCount++;
    end

    task automatic pushAttempt(input int m, input int d);
        expFrames.push_back((((d - 1) & 255) << 2) | 1);
        expFrames.push_back((((m - 1) & 255) << 2) | 3);
    endtask

    // Presents one request for a single cycle; returns the edge count of the accepting edge.
    task automatic applyStimulus(input int m, input int d, output int acceptEdge);
        if (m >= 2 && m <= 256 && d >= 1 && d <= 256) pushAttempt(m, d);
        @(negedge clk_in);
        cfg_valid = 1'b1;
        cfg_m = 9'(m);
        cfg_d = 9'(d);
        @(negedge clk_in);
        acceptEdge = edgeCount;
        cfg_valid = 1'b0;
    endtask

    task automatic waitEnRises(input int n, input int budget);
        int rises = 0;
        int cycles = 0;
        logic prev = prog_en;
        while (rises < n && cycles < budget) begin
            @(negedge clk_in);
            cycles++;
            if (prog_en && !prev) rises++;
            prev = prog_en;
        end
        if (rises < n) checkOutput("enRiseTimeout", rises, n);
    endtask

    task automatic waitIdle(input int budget);
        int cycles = 0;
        while (busy && cycles < budget) begin
            @(negedge clk_in);
            cycles++;
        end
        if (busy) checkOutput("idleTimeout", 1, 0);
    endtask

    task automatic waitDone(input int budget);
        int cycles = 0;
        while (!done_pulse && cycles < budget) begin
            @(negedge clk_in);
            cycles++;
        end
        checkOutput("doneSeen", int'(done_pulse), 1);
        if (done_pulse) begin
            @(negedge clk_in);
            checkOutput("donePulseWidth", int'(done_pulse), 0);
            checkOutput("readyAfterDone", int'(cfg_ready), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, d0, g0, r0, e0, en0, cnt;

        // Reset state and release
        repeat (3) @(negedge clk_in);
        checkOutput("rstReady", int'(cfg_ready), 0);
        checkOutput("rstProgEn", int'(prog_en), 0);
        checkOutput("rstProgData", int'(prog_data), 0);
        checkOutput("rstDcmRst", int'(dcm_rst), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstDone", int'(done_pulse), 0);
        checkOutput("rstCfgErr", int'(cfg_err), 0);
        checkOutput("rstErr", int'(err), 0);
        rstn_in = 1'b1;
        @(negedge clk_in);
        checkOutput("readyAfterRelease", int'(cfg_ready), 1);

        // Nominal M=128 D=125
        $display("[TB] nominal programming");
        d0 = doneCount; r0 = rstPulses;
        applyStimulus(128, 125, t);
        checkOutput("readyDrop", int'(cfg_ready), 0);
        checkOutput("firstProgEn", int'(prog_en), 1);
        waitEnRises(2, 100);
        repeat (3) @(negedge clk_in);
        prog_done = 1'b1;
        repeat (2) @(negedge clk_in);
        dcm_locked = 1'b1;
        waitDone(50);
        prog_done = 1'b0;
        dcm_locked = 1'b0;
        repeat (2) @(negedge clk_in);
        checkOutput("goOffset", goEdge - t + 1, 21 + 2 * GAP);
        checkOutput("nominalDoneCount", doneCount - d0, 1);
        checkOutput("nominalNoRst", rstPulses - r0, 0);
        checkOutput("nominalErr", int'(err), 0);

        // Illegal requests
        $display("[TB] illegal requests");
        e0 = cfgErrCount; en0 = enHighCount;
        applyStimulus(1, 5, t);
        checkOutput("illegalCfgErr1", int'(cfg_err), 1);
        checkOutput("illegalBusy1", int'(busy), 0);
        @(negedge clk_in);
        checkOutput("illegalCfgErrPulse1", int'(cfg_err), 0);
        applyStimulus(200, 0, t);
        checkOutput("illegalCfgErr2", int'(cfg_err), 1);
        checkOutput("illegalBusy2", int'(busy), 0);
        @(negedge clk_in);
        checkOutput("illegalCfgErrPulse2", int'(cfg_err), 0);
        repeat (3) @(negedge clk_in);
        checkOutput("illegalNoProgEn", enHighCount - en0, 0);
        checkOutput("illegalCfgErrCount", cfgErrCount - e0, 2);

        // Request presented while busy is ignored
        $display("[TB] busy rejection");
        d0 = doneCount;
        applyStimulus(100, 3, t);
        waitEnRises(1, 50);
        cnt = 0;
        cfg_valid = 1'b1; cfg_m = 9'd48; cfg_d = 9'd25;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (cfg_ready) cnt++;
        end
        cfg_valid = 1'b0;
        checkOutput("busyReadyLow", cnt, 0);
        waitEnRises(1, 50);
        prog_done = 1'b1;
        dcm_locked = 1'b1;
        waitDone(50);
        prog_done = 1'b0;
        dcm_locked = 1'b0;
        repeat (2) @(negedge clk_in);
        checkOutput("busyDoneCount", doneCount - d0, 1);

        // PROGDONE never arrives: all retries exhausted
        $display("[TB] timeout and retry");
        d0 = doneCount; g0 = goCount; r0 = rstPulses; en0 = enHighCount;
        applyStimulus(10, 4, t);
        for (int i = 0; i < RMAX; i++) pushAttempt(10, 4);
        waitIdle(2000);
        repeat (2) @(negedge clk_in);
        checkOutput("retryErr", int'(err), 1);
        checkOutput("retryAttempts", goCount - g0, RMAX + 1);
        checkOutput("retryEnCycles", enHighCount - en0, 21 * (RMAX + 1));
        checkOutput("retryRstPulses", rstPulses - r0, RMAX + 1);
        checkOutput("retryNoDone", doneCount - d0, 0);
        checkOutput("retryReady", int'(cfg_ready), 1);
        prog_done = 1'b1;
        dcm_locked = 1'b1;
        applyStimulus(5, 2, t);
        checkOutput("errClearedOnAccept", int'(err), 0);
        waitDone(100);
        prog_done = 1'b0;
        dcm_locked = 1'b0;

        // LOCKED missing on first attempt only
        $display("[TB] lock failure recovery");
        d0 = doneCount; g0 = goCount; r0 = rstPulses;
        prog_done = 1'b1;
        applyStimulus(20, 7, t);
        pushAttempt(20, 7);
        cnt = 0;
        while (!dcm_rst && cnt < 500) begin
            @(negedge clk_in);
            cnt++;
        end
        checkOutput("lockRecoverSeen", int'(dcm_rst), 1);
        dcm_locked = 1'b1;
        waitDone(300);
        prog_done = 1'b0;
        dcm_locked = 1'b0;
        repeat (2) @(negedge clk_in);
        checkOutput("lockRstPulses", rstPulses - r0, 1);
        checkOutput("lockAttempts", goCount - g0, 2);
        checkOutput("lockErr", int'(err), 0);
        checkOutput("lockDoneCount", doneCount - d0, 1);

        // Reset in the middle of LOAD_M
        $display("[TB] reset during LOAD_M");
        d0 = doneCount;
        applyStimulus(128, 125, t);
        repeat (14) @(negedge clk_in);
        checkOutput("enBeforeReset", int'(prog_en), 1);
        abortRun = 1'b1;
        rstn_in = 1'b0;
        @(negedge clk_in);
        checkOutput("resetProgEnLow", int'(prog_en), 0);
        checkOutput("resetBusyLow", int'(busy), 0);
        checkOutput("resetReadyLow", int'(cfg_ready), 0);
        rstn_in = 1'b1;
        @(negedge clk_in);
        checkOutput("resetReadyRise", int'(cfg_ready), 1);
        checkOutput("pendingFrames", expFrames.size(), 1);
        expFrames.delete();
        abortRun = 1'b0;
        repeat (20) @(negedge clk_in);
        checkOutput("resetNoDone", doneCount - d0, 0);
        prog_done = 1'b1;
        dcm_locked = 1'b1;
        applyStimulus(64, 9, t);
        waitDone(100);
        prog_done = 1'b0;
        dcm_locked = 1'b0;

        repeat (5) @(negedge clk_in);
        checkOutput("scoreboardEmpty", expFrames.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
